jk_bank_controller: RTL



---
 rtl/jk_ctrl_pkg.sv | 30 +++
 rtl/jk_bank_controller_if.sv | 25 ++
 rtl/jk_drive_gen.sv | 61 ++++++
 rtl/jk_bank_controller.sv | 96 +++++++++
 4 files changed

// File: rtl/jk_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and opcode classification for the JK bank controller.
package jk_ctrl_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP    = 3'b000;
    localparam logic [OP_W-1:0] OP_LOAD   = 3'b001;
    localparam logic [OP_W-1:0] OP_CLR    = 3'b010;
    localparam logic [OP_W-1:0] OP_CNT_UP = 3'b011;
    localparam logic [OP_W-1:0] OP_CNT_DN = 3'b100;
    localparam logic [OP_W-1:0] OP_SHL    = 3'b101;
    localparam logic [OP_W-1:0] OP_TOGGLE = 3'b110;
    localparam logic [OP_W-1:0] OP_ILL    = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Ops whose step count comes from cmd_count.
    function automatic logic is_multi_step(input logic [OP_W-1:0] op);
        return (op == OP_CNT_UP) || (op == OP_CNT_DN) || (op == OP_SHL);
    endfunction

    function automatic logic is_single_step(input logic [OP_W-1:0] op);
        return (op == OP_LOAD) || (op == OP_CLR) || (op == OP_TOGGLE);
    endfunction

endpackage

// File: rtl/jk_bank_controller_if.sv
// Command handshake between test/control logic and the JK bank controller.
interface jk_bank_controller_if
    import jk_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [WIDTH-1:0]  cmd_data;
    logic [CNT_W-1:0]  cmd_count;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count,
        output cmd_ready
    );

endinterface

// File: rtl/jk_drive_gen.sv
// Combinational per-bit J/K and ClearN drive from the latched op and live bank feedback.
module jk_drive_gen
    import jk_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic              en_i,
    input  logic [OP_W-1:0]   op_i,
    input  logic [WIDTH-1:0]  data_i,
    input  logic [WIDTH-1:0]  q_i,
    output logic [WIDTH-1:0]  j_o,
    output logic [WIDTH-1:0]  k_o,
    output logic              clear_n_o
);

    logic chain;

    always_comb begin
        j_o       = '0;
        k_o       = '0;
        clear_n_o = 1'b1;
        chain     = 1'b1;
        if (en_i) begin
            case (op_i)
                OP_LOAD: begin
                    j_o = data_i;
                    k_o = ~data_i;
                end
                OP_CLR: clear_n_o = 1'b0;
                // Toggle bit i when all lower bits are 1 (up) or all 0 (down).
                OP_CNT_UP: begin
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        j_o[i] = chain;
                        k_o[i] = chain;
                        chain  = chain & q_i[i];
                    end
                end
                OP_CNT_DN: begin
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        j_o[i] = chain;
                        k_o[i] = chain;
                        chain  = chain & ~q_i[i];
                    end
                end
                OP_SHL: begin
                    j_o[0] = data_i[0];
                    for (int i = 1; i < int'(WIDTH); i++) begin
                        j_o[i] = q_i[i-1];
                    end
                    k_o = ~j_o;
                end
                OP_TOGGLE: begin
                    j_o = data_i;
                    k_o = data_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_controller.sv
// Command sequencer for a bank of external JK flip-flops: FSM, step counter and drive generator.
module jk_bank_controller
    import jk_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  Clock,
    input  logic                  Clear,
    jk_bank_controller_if.slave   cmd,
    input  logic [WIDTH-1:0]      Q_in,
    output logic [WIDTH-1:0]      J,
    output logic [WIDTH-1:0]      K,
    output logic                  ClearN_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    state_e             state_q, state_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;
    logic               exec_en;

    assign cmd.cmd_ready = (state_q == S_IDLE) && !Clear;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign exec_en       = (state_q == S_EXEC) && !Clear;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE) && !Clear;
    assign err           = (state_q == S_DONE) && (op_q == OP_ILL) && !Clear;

    // Zero-step commands (NOP, illegal, multi-step with count 0) skip EXEC.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = cmd.cmd_op;
                    data_d = cmd.cmd_data;
                    if (is_single_step(cmd.cmd_op)) begin
                        cnt_d   = CNT_W'(1);
                        state_d = S_EXEC;
                    end else if (is_multi_step(cmd.cmd_op) && (cmd.cmd_count != '0)) begin
                        cnt_d   = cmd.cmd_count;
                        state_d = S_EXEC;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    jk_drive_gen #(
        .WIDTH (WIDTH)
    ) u_drive_gen (
        .en_i      (exec_en),
        .op_i      (op_q),
        .data_i    (data_q),
        .q_i       (Q_in),
        .j_o       (J),
        .k_o       (K),
        .clear_n_o (ClearN_out)
    );

endmodule
